// File: rtl/d_memory_mp_if.sv
// Request/response bundle between the requesters (LSU, commit logic) and the
// multi-port data memory. Each per-port field is packed, port p at slice p.
interface d_memory_mp_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int NUM_PORTS  = 2
);
  logic [NUM_PORTS-1:0]              req_valid;
  logic [NUM_PORTS-1:0]              req_ready;
  logic [NUM_PORTS-1:0]              req_write;
  logic [NUM_PORTS*ADDR_WIDTH-1:0]   req_addr;
  logic [NUM_PORTS*DATA_WIDTH-1:0]   req_wdata;
  logic [NUM_PORTS*DATA_WIDTH/8-1:0] req_be;
  logic [NUM_PORTS-1:0]              resp_valid;
  logic [DATA_WIDTH-1:0]             resp_data;
  logic                              resp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_be,
    input  req_ready, resp_valid, resp_data, resp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_be,
    output req_ready, resp_valid, resp_data, resp_err
  );
endinterface

// File: rtl/d_memory_mp.sv
// Multi-port data memory: round-robin arbitration over NUM_PORTS requesters,
// one outstanding access with a fixed BUSY latency, byte-enabled writes.
module d_memory_mp #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int DEPTH      = 1024,
  parameter int NUM_PORTS  = 2,
  parameter int DELAY      = 4,
  parameter int CNT_WIDTH  = $clog2(DELAY + 1)
) (
  input  logic         clk,
  input  logic         reset,
  d_memory_mp_if.slave bus_if
);
  localparam int BE_WIDTH  = DATA_WIDTH / 8;
  localparam int PTR_WIDTH = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam logic [ADDR_WIDTH:0]  DEPTH_L  = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DELAY - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
  logic [PTR_WIDTH-1:0]    rr_q, rr_d;
  logic [PTR_WIDTH-1:0]    port_q, port_d;
  logic                    write_q, write_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [BE_WIDTH-1:0]     be_q, be_d;
  logic [NUM_PORTS-1:0]    resp_valid_q, resp_valid_d;
  logic [DATA_WIDTH-1:0]   resp_data_q, resp_data_d;
  logic                    resp_err_q, resp_err_d;
  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

  logic                    grant_found_s;
  logic [PTR_WIDTH-1:0]    grant_idx_s;
  logic [PTR_WIDTH-1:0]    cand_s;
  logic                    take_s;
  logic [NUM_PORTS-1:0]    req_ready_s;
  logic                    addr_err_s;
  logic                    mem_we_s;

  // Round-robin search: first valid port at or above rr_q, wrapping around.
  always_comb begin
    grant_found_s = 1'b0;
    grant_idx_s   = '0;
    cand_s        = '0;
    take_s        = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      cand_s        = PTR_WIDTH'((int'(rr_q) + i) % NUM_PORTS);
      take_s        = !grant_found_s && bus_if.req_valid[cand_s];
      grant_idx_s   = take_s ? cand_s : grant_idx_s;
      grant_found_s = grant_found_s | take_s;
    end
  end

  assign addr_err_s = ({1'b0, addr_q} >= DEPTH_L);

  // Next-state, capture and response formation for the IDLE/BUSY/RESP sequence.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    rr_d         = rr_q;
    port_d       = port_q;
    write_d      = write_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    be_d         = be_q;
    resp_valid_d = '0;
    resp_data_d  = '0;
    resp_err_d   = 1'b0;
    req_ready_s  = '0;
    mem_we_s     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (grant_found_s) begin
          req_ready_s[grant_idx_s] = 1'b1;
          port_d  = grant_idx_s;
          write_d = bus_if.req_write[grant_idx_s];
          addr_d  = bus_if.req_addr[grant_idx_s*ADDR_WIDTH +: ADDR_WIDTH];
          wdata_d = bus_if.req_wdata[grant_idx_s*DATA_WIDTH +: DATA_WIDTH];
          be_d    = bus_if.req_be[grant_idx_s*BE_WIDTH +: BE_WIDTH];
          rr_d    = PTR_WIDTH'((int'(grant_idx_s) + 1) % NUM_PORTS);
          state_d = ST_BUSY;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (cnt_q == CNT_LAST) begin
          // Response is registered on entry to RESP; the array cannot change
          // during BUSY, so this equals the array contents seen in RESP.
          cnt_d                = '0;
          state_d              = ST_RESP;
          resp_valid_d[port_q] = 1'b1;
          resp_err_d           = addr_err_s;
          resp_data_d          = (!write_q && !addr_err_s) ? mem_q[addr_q] : '0;
        end else begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end
      end
      ST_RESP: begin
        mem_we_s = write_q && !addr_err_s;
        state_d  = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Control and captured-request registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      rr_q         <= '0;
      port_q       <= '0;
      write_q      <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      be_q         <= '0;
      resp_valid_q <= '0;
      resp_data_q  <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rr_q         <= rr_d;
      port_q       <= port_d;
      write_q      <= write_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      be_q         <= be_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_err_q   <= resp_err_d;
    end
  end

  // Backing array; bytes are committed on the RESP exit edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int w = 0; w < DEPTH; w++) begin
        mem_q[w] <= '0;
      end
    end else if (mem_we_s) begin
      for (int b = 0; b < BE_WIDTH; b++) begin
        if (be_q[b]) begin
          mem_q[addr_q][8*b +: 8] <= wdata_q[8*b +: 8];
        end
      end
    end
  end

  assign bus_if.req_ready  = req_ready_s;
  assign bus_if.resp_valid = resp_valid_q;
  assign bus_if.resp_data  = resp_data_q;
  assign bus_if.resp_err   = resp_err_q;
endmodule

// File: tb/tb_d_memory_mp.sv
// Scoreboard bench for d_memory_mp: a behavioural model predicts grants, timing
// and response contents; a negedge monitor compares whatever the DUT presents.
module tb_d_memory_mp;
  localparam int DW = 32, AW = 10, NP = 2, DEPTH = 1000, DELAY = 4, BW = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  d_memory_mp_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_PORTS(NP)) bus ();

  d_memory_mp #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .NUM_PORTS(NP), .DELAY(DELAY)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus_if(bus.slave)
  );

  typedef struct {
    bit            wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [BW-1:0] be;
  } req_t;

  typedef struct {
    int            port;
    logic [DW-1:0] data;
    bit            err;
    int            cyc;
  } exp_t;

  req_t          pq [NP][$];
  exp_t          sb [$];
  logic [DW-1:0] mem_model [DEPTH];
  int            model_rr;
  int            busy_until;
  int            cyc = 0;
  bit            hs_flag [NP];
  int            checks = 0;
  int            failures = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: predict ready from the model, apply accepted accesses, score responses.
  always @(negedge clk) begin
    logic [NP-1:0] exp_rdy;
    logic [DW-1:0] mask, rdata;
    logic [AW-1:0] a;
    int            g;
    bit            err;
    exp_t          e;
    if (reset) begin
      check("reset_outputs", {bus.req_ready, bus.resp_valid, bus.resp_err, bus.resp_data}, 64'd0);
    end else begin
      exp_rdy = '0;
      g = -1;
      if (cyc > busy_until) begin
        for (int k = 0; k < NP; k++) begin
          if (g < 0 && bus.req_valid[(model_rr + k) % NP]) g = (model_rr + k) % NP;
        end
      end
      if (g >= 0) exp_rdy[g] = 1'b1;
      if (exp_rdy != '0 || bus.req_ready != '0) check("req_ready", bus.req_ready, exp_rdy);
      if (g >= 0) begin
        a     = bus.req_addr[g*AW +: AW];
        err   = (int'(a) >= DEPTH);
        rdata = '0;
        if (!err && bus.req_write[g]) begin
          mask = '0;
          for (int b = 0; b < BW; b++) if (bus.req_be[g*BW + b]) mask = mask | (32'hFF << (8 * b));
          mem_model[a] = (mem_model[a] & ~mask) | (bus.req_wdata[g*DW +: DW] & mask);
        end else if (!err) begin
          rdata = mem_model[a];
        end
        sb.push_back('{port: g, data: rdata, err: err, cyc: cyc});
        model_rr   = (g + 1) % NP;
        busy_until = cyc + DELAY + 1;
        hs_flag[g] = 1'b1;
      end
      if (sb.size() > 0 && cyc == sb[0].cyc + DELAY + 1) begin
        e = sb.pop_front();
        check("resp_valid", bus.resp_valid, 64'(1) << e.port);
        check("resp_data", bus.resp_data, e.data);
        check("resp_err", bus.resp_err, e.err);
      end else if (bus.resp_valid != '0) begin
        check("resp_unexpected", bus.resp_valid, 64'd0);
      end
    end
  end

  task automatic req(int p, bit wr, logic [AW-1:0] addr, logic [DW-1:0] data, logic [BW-1:0] be);
    pq[p].push_back('{wr: wr, addr: addr, data: data, be: be});
  endtask

  // One clock of driving: retire accepted requests, present the next queued ones.
  task automatic step();
    req_t r;
    @(posedge clk);
    #2;
    for (int p = 0; p < NP; p++) begin
      if (hs_flag[p]) begin
        bus.req_valid[p] = 1'b0;
        hs_flag[p] = 1'b0;
      end
      if (!bus.req_valid[p] && pq[p].size() > 0) begin
        r = pq[p].pop_front();
        bus.req_write[p]           = r.wr;
        bus.req_addr[p*AW +: AW]   = r.addr;
        bus.req_wdata[p*DW +: DW]  = r.data;
        bus.req_be[p*BW +: BW]     = r.be;
        bus.req_valid[p]           = 1'b1;
      end
    end
  endtask

  task automatic drain(int limit);
    int n = 0;
    while ((pq[0].size() > 0 || pq[1].size() > 0 || bus.req_valid != '0 || sb.size() > 0) && n < limit) begin
      step();
      n++;
    end
    check("drain_timeout", 64'(n < limit), 64'd1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.req_valid = '0;
    for (int p = 0; p < NP; p++) begin
      pq[p].delete();
      hs_flag[p] = 1'b0;
    end
    sb.delete();
    model_rr   = 0;
    busy_until = -100;
    for (int i = 0; i < DEPTH; i++) mem_model[i] = '0;
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b0;
  endtask

  initial begin
    int n;
    bus.req_valid = '0;
    bus.req_write = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_be    = '0;
    do_reset();

    // Single read of a never-written word.
    req(0, 1'b0, 10'd5, 32'h0, 4'h0);
    drain(100);

    // Full write by port1, read back by port0, then a partial overwrite.
    req(1, 1'b1, 10'd7, 32'hAABBCCDD, 4'hF);
    drain(100);
    req(0, 1'b0, 10'd7, 32'h0, 4'h0);
    drain(100);
    req(0, 1'b1, 10'd7, 32'h11223344, 4'b0011);
    drain(100);
    req(1, 1'b0, 10'd7, 32'h0, 4'h0);
    drain(100);
    req(1, 1'b1, 10'd7, 32'hDEADBEEF, 4'h0);
    req(1, 1'b0, 10'd7, 32'h0, 4'h0);
    drain(100);

    // Both ports contending continuously.
    for (int i = 0; i < 4; i++) begin
      req(0, 1'b1, 10'(20 + i), $urandom, 4'hF);
      req(1, 1'b0, 10'(20 + i), 32'h0, 4'h0);
    end
    drain(200);

    // Out-of-range and boundary addresses.
    req(0, 1'b0, 10'd1023, 32'h0, 4'h0);
    req(1, 1'b1, 10'd1010, 32'h12345678, 4'hF);
    req(0, 1'b1, 10'd999, 32'hCAFEF00D, 4'hF);
    req(1, 1'b0, 10'd1000, 32'h0, 4'h0);
    req(1, 1'b0, 10'd999, 32'h0, 4'h0);
    drain(200);

    // Reset two cycles into BUSY aborts a write.
    req(0, 1'b1, 10'd3, 32'hFFFFFFFF, 4'hF);
    n = 0;
    while ((pq[0].size() > 0 || bus.req_valid[0]) && n < 50) begin
      step();
      n++;
    end
    check("abort_handshake_timeout", 64'(n < 50), 64'd1);
    step();
    step();
    do_reset();
    req(0, 1'b0, 10'd3, 32'h0, 4'h0);
    req(1, 1'b0, 10'd3, 32'h0, 4'h0);
    drain(100);

    // Randomised traffic with gaps and contention.
    for (int i = 0; i < 80; i++) begin
      logic [AW-1:0] a;
      a = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(990, 1023)) : AW'($urandom_range(0, 15));
      req($urandom_range(0, NP - 1), 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)));
      repeat ($urandom_range(0, 3)) step();
    end
    drain(2000);

    repeat (10) step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end
endmodule
